// File: rtl/scan_test_controller.sv
// Scan-test sequencer for the golden datapath chain: loads a stimulus/expected pair,
// shifts it in LSB first, strobes one capture, shifts the response out and scores it.
module scan_test_controller #(
    parameter int CHAIN_LEN = 5,
    parameter int CNT_W     = 8
) (
    input  logic                 refclk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic                 pat_last,
    input  logic [CHAIN_LEN-1:0] pat_stim,
    input  logic [CHAIN_LEN-1:0] pat_exp,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 capture,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [CNT_W-1:0]     pat_cnt
);

    localparam int                BIT_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_SHIFT_IN  = 3'd2;
    localparam logic [2:0] S_CAPTURE   = 3'd3;
    localparam logic [2:0] S_SHIFT_OUT = 3'd4;
    localparam logic [2:0] S_CHECK     = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]           state_q,   state_d;
    logic [BIT_W-1:0]     bitIdx_q,  bitIdx_d;
    logic [CHAIN_LEN-1:0] stim_q,    stim_d;
    logic [CHAIN_LEN-1:0] exp_q,     exp_d;
    logic [CHAIN_LEN-1:0] resp_q,    resp_d;
    logic                 last_q,    last_d;
    logic [CNT_W-1:0]     failCnt_q, failCnt_d;
    logic [CNT_W-1:0]     patCnt_q,  patCnt_d;
    logic                 scanEn_q,  scanEn_d;
    logic                 scanIn_q,  scanIn_d;
    logic                 capture_q, capture_d;
    logic                 ready_q,   ready_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic                 pass_q,    pass_d;

    // Every output flop is loaded with the value belonging to the state being entered,
    // so the pins are glitch-free and never combinational from the inputs.
    always_comb begin
        state_d   = state_q;
        bitIdx_d  = bitIdx_q;
        stim_d    = stim_q;
        exp_d     = exp_q;
        resp_d    = resp_q;
        last_d    = last_q;
        failCnt_d = failCnt_q;
        patCnt_d  = patCnt_q;
        done_d    = done_q;
        pass_d    = pass_q;
        scanEn_d  = 1'b0;
        scanIn_d  = 1'b0;
        capture_d = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d   = S_LOAD;
                        failCnt_d = '0;
                        patCnt_d  = '0;
                        done_d    = 1'b0;
                        pass_d    = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (pat_valid && ready_q) begin
                        state_d  = S_SHIFT_IN;
                        stim_d   = pat_stim;
                        exp_d    = pat_exp;
                        last_d   = pat_last;
                        bitIdx_d = '0;
                        scanEn_d = 1'b1;
                        scanIn_d = pat_stim[0];
                    end
                end
                S_SHIFT_IN: begin
                    // stim_q is consumed as a shift register; bit 0 is always on the pin.
                    if (bitIdx_q == LAST_BIT) begin
                        state_d   = S_CAPTURE;
                        capture_d = 1'b1;
                    end else begin
                        bitIdx_d = bitIdx_q + BIT_W'(1);
                        stim_d   = stim_q >> 1;
                        scanEn_d = 1'b1;
                        scanIn_d = stim_q[1];
                    end
                end
                S_CAPTURE: begin
                    state_d  = S_SHIFT_OUT;
                    bitIdx_d = '0;
                    scanEn_d = 1'b1;
                end
                S_SHIFT_OUT: begin
                    // First sampled tail bit ends up in resp[0] after CHAIN_LEN shifts.
                    resp_d = {scan_out, resp_q[CHAIN_LEN-1:1]};
                    if (bitIdx_q == LAST_BIT) begin
                        state_d = S_CHECK;
                    end else begin
                        bitIdx_d = bitIdx_q + BIT_W'(1);
                        scanEn_d = 1'b1;
                    end
                end
                S_CHECK: begin
                    if ((resp_q != exp_q) && (failCnt_q != CNT_MAX)) begin
                        failCnt_d = failCnt_q + CNT_W'(1);
                    end
                    patCnt_d = patCnt_q + CNT_W'(1);
                    if (last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (failCnt_d == '0);
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge refclk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bitIdx_q  <= '0;
            stim_q    <= '0;
            exp_q     <= '0;
            resp_q    <= '0;
            last_q    <= 1'b0;
            failCnt_q <= '0;
            patCnt_q  <= '0;
            scanEn_q  <= 1'b0;
            scanIn_q  <= 1'b0;
            capture_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitIdx_q  <= bitIdx_d;
            stim_q    <= stim_d;
            exp_q     <= exp_d;
            resp_q    <= resp_d;
            last_q    <= last_d;
            failCnt_q <= failCnt_d;
            patCnt_q  <= patCnt_d;
            scanEn_q  <= scanEn_d;
            scanIn_q  <= scanIn_d;
            capture_q <= capture_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign pat_ready = ready_q;
    assign scan_en   = scanEn_q;
    assign scan_in   = scanIn_q;
    assign capture   = capture_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_cnt  = failCnt_q;
    assign pat_cnt   = patCnt_q;

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: a scan-chain model with a configurable capture
// function, a timeline-level reference of the session, and directed plus random runs.
module tb_scan_test_controller;

    localparam int N     = 5;
    localparam int CNT_W = 8;
    localparam int TLAST = 2 * N + 2;
    localparam int MAXF  = (1 << CNT_W) - 1;

    logic             refclk = 1'b0;
    logic             reset_n, start, abort, pat_valid, pat_last;
    logic [N-1:0]     pat_stim, pat_exp;
    logic             pat_ready, scan_en, scan_in, scan_out, capture, busy, done, pass;
    logic [CNT_W-1:0] fail_cnt, pat_cnt;

    logic [N-1:0] chain;
    logic [N-1:0] bfmMask;

    int errors = 0;
    int checks = 0;
    bit chkOn  = 1'b0;

    // Session reference: mode 0 idle, 1 waiting for a pattern, 2 running, 3 done.
    // While running, mT counts cycles since the accepting handshake.
    int           mMode, mT, mFail, mPat;
    logic [N-1:0] mStim, mExp, mMask;
    logic         mLast;

    scan_test_controller #(.CHAIN_LEN(N), .CNT_W(CNT_W)) dut (
        .refclk(refclk), .reset_n(reset_n), .start(start), .abort(abort),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_last(pat_last),
        .pat_stim(pat_stim), .pat_exp(pat_exp), .scan_en(scan_en),
        .scan_in(scan_in), .scan_out(scan_out), .capture(capture), .busy(busy),
        .done(done), .pass(pass), .fail_cnt(fail_cnt), .pat_cnt(pat_cnt)
    );

    always #5 refclk = ~refclk;

    // Datapath chain: head takes scan_in, tail drives scan_out; capture applies XOR mask.
    assign scan_out = chain[0];
    always @(posedge refclk) begin
        if (capture)      chain <= chain ^ bfmMask;
        else if (scan_en) chain <= {scan_in, chain[N-1:1]};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelEdge();
        if (!reset_n) begin
            mMode = 0; mFail = 0; mPat = 0; mT = 0;
        end else if (abort) begin
            mMode = 0;
        end else begin
            case (mMode)
                0, 3: if (start) begin mMode = 1; mFail = 0; mPat = 0; end
                1: if (pat_valid) begin
                    mStim = pat_stim; mExp = pat_exp; mLast = pat_last;
                    mMask = bfmMask; mMode = 2; mT = 1;
                end
                2: if (mT == TLAST) begin
                    if (((mStim ^ mMask) != mExp) && mFail < MAXF) mFail++;
                    mPat  = (mPat + 1) % (1 << CNT_W);
                    mMode = mLast ? 3 : 1;
                end else begin
                    mT++;
                end
                default: mMode = 0;
            endcase
        end
    endtask

    task automatic stepCycle();
        @(posedge refclk);
        modelEdge();
        #1;
    endtask

    // Per-cycle comparison of every output against the session reference.
    always @(negedge refclk) begin
        if (chkOn) begin
            logic run, expEn, expIn, expCap;
            run    = (mMode == 2);
            expEn  = run && ((mT >= 1 && mT <= N) || (mT >= N + 2 && mT <= 2 * N + 1));
            expIn  = (run && mT >= 1 && mT <= N) ? mStim[mT-1] : 1'b0;
            expCap = run && (mT == N + 1);
            checkOutput("scan_en", 32'(scan_en), 32'(expEn));
            checkOutput("scan_in", 32'(scan_in), 32'(expIn));
            checkOutput("capture", 32'(capture), 32'(expCap));
            checkOutput("pat_ready", 32'(pat_ready), 32'(mMode == 1));
            checkOutput("busy", 32'(busy), 32'(mMode == 1 || mMode == 2));
            checkOutput("done", 32'(done), 32'(mMode == 3));
            checkOutput("pass", 32'(pass), 32'(mMode == 3 && mFail == 0));
            checkOutput("fail_cnt", 32'(fail_cnt), 32'(mFail));
            checkOutput("pat_cnt", 32'(pat_cnt), 32'(mPat));
        end
    end

    task automatic pulseStart();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
    endtask

    // One pattern: optional idle wait in LOAD, handshake, then noise on the ignored inputs.
    task automatic applyStimulus(input logic [N-1:0] stim, input logic [N-1:0] exp,
                                 input logic last, input logic [N-1:0] mask, input int idle);
        for (int i = 0; i < idle; i++) begin
            pat_valid = 1'b0;
            pat_stim  = N'($urandom);
            stepCycle();
        end
        pat_valid = 1'b1; pat_stim = stim; pat_exp = exp; pat_last = last; bfmMask = mask;
        stepCycle();
        for (int i = 0; i < TLAST; i++) begin
            pat_valid = 1'($urandom);
            pat_stim  = N'($urandom);
            pat_last  = 1'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            stepCycle();
        end
        pat_valid = 1'b0; start = 1'b0; pat_last = 1'b0;
    endtask

    initial begin
        logic [N-1:0] seq, stim, exp, mask;
        int capCount, capAt, nPat, f0, p0;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; pat_valid = 1'b0; pat_last = 1'b0;
        pat_stim = '0; pat_exp = '0; bfmMask = '0;
        stepCycle(); stepCycle();
        chkOn = 1'b1;
        checkOutput("reset scan_en", 32'(scan_en), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset pat_ready", 32'(pat_ready), 0);
        checkOutput("reset pat_cnt", 32'(pat_cnt), 0);
        reset_n = 1'b1;
        stepCycle();

        // Single passing pattern on a plain loopback chain.
        pulseStart();
        checkOutput("load pat_ready", 32'(pat_ready), 1);
        pat_valid = 1'b1; pat_stim = 5'b10110; pat_exp = 5'b10110; pat_last = 1'b1;
        stepCycle();
        pat_valid = 1'b0;
        seq = '0; capCount = 0; capAt = 0;
        for (int c = 1; c <= TLAST; c++) begin
            if (c <= N) seq[c-1] = scan_in;
            if (capture) begin capCount++; capAt = c; end
            if (c == TLAST) begin
                checkOutput("check busy", 32'(busy), 1);
                checkOutput("check done", 32'(done), 0);
            end
            stepCycle();
        end
        checkOutput("scan_in sequence", 32'(seq), 32'(5'b10110));
        checkOutput("capture count", 32'(capCount), 1);
        checkOutput("capture cycle", 32'(capAt), 6);
        checkOutput("single done", 32'(done), 1);
        checkOutput("single pass", 32'(pass), 1);
        checkOutput("single fail_cnt", 32'(fail_cnt), 0);
        checkOutput("single pat_cnt", 32'(pat_cnt), 1);

        // Three patterns, the middle one expecting 00001 while the chain returns 00100.
        pulseStart();
        applyStimulus(5'b01011, 5'b01011, 1'b0, '0, 0);
        applyStimulus(5'b00100, 5'b00001, 1'b0, '0, 0);
        applyStimulus(5'b11000, 5'b11000, 1'b1, '0, 0);
        checkOutput("mismatch fail_cnt", 32'(fail_cnt), 1);
        checkOutput("mismatch pat_cnt", 32'(pat_cnt), 3);
        checkOutput("mismatch pass", 32'(pass), 0);

        // Back-pressure: four idle cycles in LOAD before the pattern is offered.
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp pat_ready", 32'(pat_ready), 1);
            checkOutput("bp scan_en", 32'(scan_en), 0);
            stepCycle();
        end
        applyStimulus(5'b00111, 5'b00110, 1'b1, 5'b00001, 0);
        checkOutput("bp pass", 32'(pass), 1);
        checkOutput("bp pat_cnt", 32'(pat_cnt), 1);

        // Abort in the handshake cycle, then abort at SHIFT_OUT bit 2 of the second pattern.
        pulseStart();
        pat_valid = 1'b1; abort = 1'b1; pat_stim = 5'b11111;
        stepCycle();
        abort = 1'b0; pat_valid = 1'b0;
        checkOutput("abort hs busy", 32'(busy), 0);
        pulseStart();
        applyStimulus(5'b10101, 5'b00000, 1'b0, '0, 1);
        f0 = 32'(fail_cnt); p0 = 32'(pat_cnt);
        pat_valid = 1'b1; pat_stim = 5'b01101; pat_exp = 5'b01101; pat_last = 1'b1;
        stepCycle();
        pat_valid = 1'b0;
        repeat (N + 3) stepCycle();
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("abort scan_en", 32'(scan_en), 0);
        checkOutput("abort capture", 32'(capture), 0);
        checkOutput("abort done", 32'(done), 0);
        checkOutput("abort fail_cnt", 32'(fail_cnt), 1);
        checkOutput("abort pat_cnt", 32'(pat_cnt), 1);
        checkOutput("abort hold", 32'(fail_cnt + pat_cnt), 32'(f0 + p0));
        pulseStart();
        applyStimulus(5'b01101, 5'b01101, 1'b1, '0, 0);
        checkOutput("post-abort pass", 32'(pass), 1);

        // Reset asserted for two edges in the middle of SHIFT_IN.
        pulseStart();
        pat_valid = 1'b1; pat_stim = 5'b11001; pat_exp = 5'b11001; pat_last = 1'b1;
        stepCycle();
        pat_valid = 1'b0;
        stepCycle();
        reset_n = 1'b0;
        stepCycle(); stepCycle();
        checkOutput("midreset scan_en", 32'(scan_en), 0);
        checkOutput("midreset busy", 32'(busy), 0);
        reset_n = 1'b1;
        stepCycle();

        // Random sessions; capture may corrupt the response through a random mask.
        for (int s = 0; s < 8; s++) begin
            pulseStart();
            nPat = $urandom_range(1, 6);
            for (int p = 0; p < nPat; p++) begin
                stim = N'($urandom);
                mask = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
                exp  = ($urandom_range(0, 1) == 1) ? (stim ^ mask) : N'($urandom);
                applyStimulus(stim, exp, (p == nPat - 1), mask, $urandom_range(0, 3));
            end
            repeat ($urandom_range(1, 3)) stepCycle();
        end

        // Saturation: 260 failing patterns leave fail_cnt at 255 and pat_cnt wrapped to 4.
        pulseStart();
        for (int p = 0; p < 260; p++) begin
            stim = N'($urandom);
            applyStimulus(stim, ~stim, (p == 259), '0, 0);
        end
        checkOutput("sat fail_cnt", 32'(fail_cnt), 255);
        checkOutput("sat pat_cnt", 32'(pat_cnt), 4);
        checkOutput("sat pass", 32'(pass), 0);

        stepCycle();
        chkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_test_controller.md
Name: scan_test_controller

Overview:
- Sequences scan-based test of the 5-bit golden datapath register chain. Accepts one stimulus/expected-response pattern pair at a time over a valid/ready handshake. Shifts the stimulus in, pulses one capture cycle, then shifts the response out and compares it.
- Sits between the DFT pattern source and the datapath's scan-enable/scan-in/scan-out pins. Reports pass/fail and a saturating mismatch count.

Parameters:
- CHAIN_LEN, 5, number of scan flops in the datapath chain (≥2).
- CNT_W, 8, width of pattern and fail counters.

Ports:
- refclk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  1-cycle pulse; begins a test session from IDLE. Ignored elsewhere.
- abort  input  1  forces return to IDLE on next edge; highest priority after reset.
- pat_valid  input  1  pattern source has a pair on pat_stim/pat_exp.
- pat_ready  output  1  controller accepts the pair this cycle.
- pat_last  input  1  qualifies the final pattern of the session; sampled with the handshake.
- pat_stim  input  CHAIN_LEN  stimulus vector.
- pat_exp  input  CHAIN_LEN  expected captured response.
- scan_en  output  1  datapath scan-enable (1 = shift, 0 = functional/capture).
- scan_in  output  1  serial data into chain head.
- scan_out  input  1  serial data from chain tail.
- capture  output  1  1-cycle strobe coinciding with the capture edge.
- busy  output  1  high in any state except IDLE and DONE.
- done  output  1  high in DONE until next start or reset.
- pass  output  1  valid with done; 1 iff fail_cnt==0.
- fail_cnt  output  CNT_W  patterns with ≥1 mismatching bit; saturates at all-ones.
- pat_cnt  output  CNT_W  patterns completed this session; wraps.

Behaviour:
- Reset (reset_n=0 at edge): state=IDLE. Outputs: scan_en=0, scan_in=0, capture=0, pat_ready=0, busy=0, done=0, pass=0, fail_cnt=0, pat_cnt=0. Internal shift/response registers are cleared.
- States: IDLE, LOAD, SHIFT_IN, CAPTURE, SHIFT_OUT, CHECK, DONE.
- IDLE: start → LOAD. fail_cnt, pat_cnt and done are cleared on that edge.
- LOAD: pat_ready=1 (registered, asserted for the whole state). On pat_valid&&pat_ready the controller latches stim, exp and last, then goes to SHIFT_IN. Without pat_valid it waits indefinitely.
- SHIFT_IN: exactly CHAIN_LEN cycles with scan_en=1. On cycle k (0-based), scan_in=stim[k] (LSB first). A bit counter runs 0..CHAIN_LEN-1, then the state moves to CAPTURE.
- CAPTURE: one cycle with scan_en=0, capture=1, scan_in=0.
- SHIFT_OUT: exactly CHAIN_LEN cycles with scan_en=1 and scan_in=0. At each edge in this state scan_out is sampled into resp[k], k=0..CHAIN_LEN-1. resp[0] is the tail bit present before the first shift.
- CHECK: one cycle. If resp!=exp, fail_cnt increments unless it is all-ones. pat_cnt increments (wrap). Next state is DONE if last=1, else LOAD.
- DONE: done=1, pass=(fail_cnt==0), busy=0. start → LOAD with counters cleared, as from IDLE.
- Latency per pattern: 1 handshake cycle + CHAIN_LEN + 1 + CHAIN_LEN + 1 = 2·CHAIN_LEN+3 cycles (13 for CHAIN_LEN=5).
- All outputs are registered; none is combinational from inputs.
- abort: in any state, next edge goes to IDLE. scan_en, capture and pat_ready drop to 0. fail_cnt and pat_cnt hold their values; done=0. A handshake in the same cycle as abort is not consumed, so pat_ready is treated as 0 for that cycle.
- Precedence: reset_n > abort > start > normal transitions.
- start while busy is ignored.
- reset_n low mid-shift: chain contents are undefined; the controller returns to IDLE with reset values the next edge.

Test Plan:
- Reset: hold reset_n=0 for 2 edges during SHIFT_IN → all outputs at reset values, state IDLE, scan_en=0.
- Single pass: start, one pattern stim=5'b10110, exp=5'b10110, last=1, loopback chain (scan_out = chain tail, capture holds) → scan_in sequence 0,1,1,0,1; capture high exactly 1 cycle at cycle 6 after handshake; done=1, pass=1, fail_cnt=0, pat_cnt=1; 13 cycles from handshake to CHECK exit.
- Mismatch: 3 patterns, 2nd with exp=5'b00001 while chain returns 5'b00100 → fail_cnt=1, pat_cnt=3, pass=0.
- Back-pressure: pat_valid low for 4 cycles in LOAD → pat_ready stays 1, scan_en stays 0, no counter change; pattern accepted on the first valid cycle.
- Abort mid SHIFT_OUT at bit 2 → next edge IDLE, scan_en=0, capture=0, fail_cnt and pat_cnt unchanged, done=0. A following start runs cleanly.
- Saturation: CNT_W=2, 5 failing patterns → fail_cnt=3 (held), pat_cnt=1 (wrapped).
